// File: rtl/battleship_pkg.sv
// Shared types and defaults for the board cursor.
//   GRID_ROWS / GRID_COLS : default board dimensions
//   dir_t                 : decoded per-axis button direction
//   rep_state_t           : per-axis hold/auto-repeat state
//   decode_dir()          : maps a dec/inc button pair onto dir_t
package battleship_pkg;

   localparam int GRID_ROWS = 10;
   localparam int GRID_COLS = 10;

   typedef enum logic [1:0] {DIR_NONE, DIR_DEC, DIR_INC} dir_t;

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

   // Both buttons pressed cancel each other out.
   function automatic dir_t decode_dir(input logic dec, input logic inc);
      dir_t d;
      d = DIR_NONE;
      if (dec && !inc) d = DIR_DEC;
      if (inc && !dec) d = DIR_INC;
      return d;
   endfunction

endpackage

// File: rtl/axis_stepper.sv
// One cursor axis: hold-to-auto-repeat FSM, its cycle counter and the
// position register.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   enable          : 0 freezes the position and parks the FSM in IDLE
//   btn_dec/btn_inc : move towards 0 / towards MAX
//   pos             : current position, 0..MAX
module axis_stepper
   import battleship_pkg::*;
#(
   parameter int MAX          = 9,
   parameter int WRAP         = 0,
   parameter int REPEAT_DELAY = 50_000_000,
   parameter int REPEAT_RATE  = 10_000_000,
   parameter int W            = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic         btn_dec,
   input  logic         btn_inc,
   output logic [W-1:0] pos
);

   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
   localparam logic [W-1:0]     POS_MAX    = W'(MAX);

   // One step in direction d, saturating or wrapping at the edges.
   function automatic logic [W-1:0] step_pos(input logic [W-1:0] p, input dir_t d);
      logic [W-1:0] n;
      n = p;
      if (d == DIR_INC) begin
         if (p == POS_MAX) n = (WRAP != 0) ? '0 : p;
         else              n = p + 1'b1;
      end else if (d == DIR_DEC) begin
         if (p == '0) n = (WRAP != 0) ? POS_MAX : p;
         else         n = p - 1'b1;
      end
      return n;
   endfunction

   dir_t             dir;
   dir_t             dir_prev;
   rep_state_t       state;
   rep_state_t       state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic             step;

   assign dir = decode_dir(btn_dec, btn_inc);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      step     = 1'b0;
      if (!enable || dir == DIR_NONE) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end else begin
         case (state)
            // Only a fresh press moves from IDLE; a button held across
            // enable rising has dir == dir_prev and is ignored.
            IDLE: begin
               if (dir != dir_prev) begin
                  step     = 1'b1;
                  state_nx = DELAY;
                  cnt_nx   = '0;
               end
            end
            DELAY, REPEAT: begin
               if (dir != dir_prev) begin
                  // Direction flipped without release: restart the hold.
                  step     = 1'b1;
                  state_nx = DELAY;
                  cnt_nx   = '0;
               end else if (cnt == ((state == DELAY) ? DELAY_LAST : RATE_LAST)) begin
                  step     = 1'b1;
                  state_nx = REPEAT;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
            default: begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         dir_prev <= DIR_NONE;
         pos      <= '0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         // Sampled regardless of enable so held buttons are remembered.
         dir_prev <= dir;
         if (step) pos <= step_pos(pos, dir);
      end
   end

endmodule

// File: rtl/grid_cursor_ctrl.sv
// Row/column cursor on a ROWS x COLS board with optional wrap-around,
// per-axis hold-to-repeat and a turn enable. Produces the flat cell index
// and a one-cycle shot pulse with the captured cell.
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   enable                              : 1 = player's turn
//   btn_up/btn_down/btn_left/btn_right  : debounced direction buttons
//   btn_select                          : fire request
//   cursor_row, cursor_col              : cursor position
//   selected_cell                       : row*COLS+col
//   shot_select                         : one-cycle pulse per accepted fire
//   shot_cell                           : selected_cell captured at the shot
module grid_cursor_ctrl
   import battleship_pkg::*;
#(
   parameter int ROWS         = GRID_ROWS,
   parameter int COLS         = GRID_COLS,
   parameter int WRAP         = 0,
   parameter int REPEAT_DELAY = 50_000_000,
   parameter int REPEAT_RATE  = 10_000_000,
   localparam int RW          = $clog2(ROWS),
   localparam int CWD         = $clog2(COLS),
   localparam int CELL_W      = $clog2(ROWS * COLS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              btn_up,
   input  logic              btn_down,
   input  logic              btn_left,
   input  logic              btn_right,
   input  logic              btn_select,
   output logic [RW-1:0]     cursor_row,
   output logic [CWD-1:0]    cursor_col,
   output logic [CELL_W-1:0] selected_cell,
   output logic              shot_select,
   output logic [CELL_W-1:0] shot_cell
);

   logic select_prev;

   axis_stepper #(
      .MAX          (ROWS - 1),
      .WRAP         (WRAP),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .W            (RW)
   ) u_row (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .btn_dec (btn_up),
      .btn_inc (btn_down),
      .pos     (cursor_row)
   );

   axis_stepper #(
      .MAX          (COLS - 1),
      .WRAP         (WRAP),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .W            (CWD)
   ) u_col (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .btn_dec (btn_left),
      .btn_inc (btn_right),
      .pos     (cursor_col)
   );

   // Row and column are always in range, so the result fits CELL_W bits.
   assign selected_cell = CELL_W'(cursor_row) * CELL_W'(COLS) + CELL_W'(cursor_col);

   // shot_cell is loaded from the pre-move index, since selected_cell is
   // still driven by the old row/col registers at this edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         select_prev <= 1'b0;
         shot_select <= 1'b0;
         shot_cell   <= '0;
      end else begin
         select_prev <= btn_select;
         shot_select <= btn_select & ~select_prev & enable;
         if (btn_select && !select_prev && enable) shot_cell <= selected_cell;
      end
   end

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// Directed bench for grid_cursor_ctrl. Four instances with independent
// stimulus: default parameters, fast repeat (saturate), fast repeat (wrap)
// and an 8x12 board with fast repeat.
module tb_grid_cursor_ctrl;

   localparam logic [4:0] B_UP = 5'b10000;
   localparam logic [4:0] B_DN = 5'b01000;
   localparam logic [4:0] B_LF = 5'b00100;
   localparam logic [4:0] B_RT = 5'b00010;
   localparam logic [4:0] B_SL = 5'b00001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] rst, en, up, down, left, right, sel;

   logic [3:0] d_row, d_col;  logic [6:0] d_cell, d_scell;  logic d_shot;
   logic [3:0] f_row, f_col;  logic [6:0] f_cell, f_scell;  logic f_shot;
   logic [3:0] w_row, w_col;  logic [6:0] w_cell, w_scell;  logic w_shot;
   logic [2:0] s_row; logic [3:0] s_col; logic [6:0] s_cell, s_scell; logic s_shot;

   int tests = 0;
   int fails = 0;

   grid_cursor_ctrl u_def (
      .clk(clk), .reset(rst[0]), .enable(en[0]), .btn_up(up[0]), .btn_down(down[0]),
      .btn_left(left[0]), .btn_right(right[0]), .btn_select(sel[0]),
      .cursor_row(d_row), .cursor_col(d_col), .selected_cell(d_cell),
      .shot_select(d_shot), .shot_cell(d_scell));

   grid_cursor_ctrl #(.WRAP(0), .REPEAT_DELAY(4), .REPEAT_RATE(2)) u_fast (
      .clk(clk), .reset(rst[1]), .enable(en[1]), .btn_up(up[1]), .btn_down(down[1]),
      .btn_left(left[1]), .btn_right(right[1]), .btn_select(sel[1]),
      .cursor_row(f_row), .cursor_col(f_col), .selected_cell(f_cell),
      .shot_select(f_shot), .shot_cell(f_scell));

   grid_cursor_ctrl #(.WRAP(1), .REPEAT_DELAY(4), .REPEAT_RATE(2)) u_wrap (
      .clk(clk), .reset(rst[2]), .enable(en[2]), .btn_up(up[2]), .btn_down(down[2]),
      .btn_left(left[2]), .btn_right(right[2]), .btn_select(sel[2]),
      .cursor_row(w_row), .cursor_col(w_col), .selected_cell(w_cell),
      .shot_select(w_shot), .shot_cell(w_scell));

   grid_cursor_ctrl #(.ROWS(8), .COLS(12), .REPEAT_DELAY(4), .REPEAT_RATE(2)) u_small (
      .clk(clk), .reset(rst[3]), .enable(en[3]), .btn_up(up[3]), .btn_down(down[3]),
      .btn_left(left[3]), .btn_right(right[3]), .btn_select(sel[3]),
      .cursor_row(s_row), .cursor_col(s_col), .selected_cell(s_cell),
      .shot_select(s_shot), .shot_cell(s_scell));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_btn(input int i, input logic [4:0] b);
      up[i]    = b[4];
      down[i]  = b[3];
      left[i]  = b[2];
      right[i] = b[1];
      sel[i]   = b[0];
   endtask

   // Press for one sampled edge, then release for one edge.
   task automatic tap(input int i, input logic [4:0] b);
      set_btn(i, b);
      tick;
      set_btn(i, 5'b0);
      tick;
   endtask

   int exp_col2 [10] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4};

   initial begin
      rst = '1; en = '1; up = '0; down = '0; left = '0; right = '0; sel = '0;
      tick;
      tick;
      rst = '0;

      // Reset state
      chk("rst_def_row",   32'(d_row),   0);
      chk("rst_def_col",   32'(d_col),   0);
      chk("rst_def_cell",  32'(d_cell),  0);
      chk("rst_def_shot",  32'(d_shot),  0);
      chk("rst_def_scell", 32'(d_scell), 0);
      chk("rst_fast_shot", 32'(f_shot),  0);
      chk("rst_wrap_shot", 32'(w_shot),  0);
      chk("rst_wrap_scel", 32'(w_scell), 0);
      chk("rst_small_sht", 32'(s_shot),  0);
      chk("rst_small_scl", 32'(s_scell), 0);

      // 1: single down press with default parameters
      set_btn(0, B_DN);
      tick;
      set_btn(0, 5'b0);
      chk("t1_row",  32'(d_row),  1);
      chk("t1_col",  32'(d_col),  0);
      chk("t1_cell", 32'(d_cell), 10);
      chk("t1_shot", 32'(d_shot), 0);
      tick;
      chk("t1_row_hold", 32'(d_row), 1);

      // 2: hold right 10 edges, steps at 1,5,7,9
      set_btn(1, B_RT);
      for (int k = 0; k < 10; k++) begin
         tick;
         chk($sformatf("t2_col_e%0d", k + 1), 32'(f_col), 32'(exp_col2[k]));
      end
      set_btn(1, 5'b0);
      tick;
      tick;
      tick;
      chk("t2_col_release", 32'(f_col), 4);

      // 3: edges, saturate vs wrap
      tap(1, B_UP);
      chk("t3_sat_row", 32'(f_row), 0);
      tap(2, B_UP);
      chk("t3_wrap_row",  32'(w_row),  9);
      chk("t3_wrap_cell", 32'(w_cell), 90);
      tap(2, B_LF);
      chk("t3_wrap_col",   32'(w_col),  9);
      chk("t3_wrap_cell2", 32'(w_cell), 99);
      tap(2, B_DN);
      chk("t3_wrap_row0",  32'(w_row),  0);
      chk("t3_wrap_cell3", 32'(w_cell), 9);

      // 4: opposing buttons, diagonal, direction flip
      tap(2, B_UP | B_DN);
      chk("t4_both_row", 32'(w_row), 0);
      tap(1, B_DN);
      tap(1, B_DN);
      tap(1, B_DN);
      tap(1, B_LF);
      chk("t4_cell33", 32'(f_cell), 33);
      tap(1, B_LF | B_DN);
      chk("t4_diag_row",  32'(f_row),  4);
      chk("t4_diag_col",  32'(f_col),  2);
      chk("t4_diag_cell", 32'(f_cell), 42);
      set_btn(1, B_LF);
      tick;
      chk("t4_left_step", 32'(f_col), 1);
      tick;
      chk("t4_left_hold", 32'(f_col), 1);
      set_btn(1, B_RT);
      tick;
      chk("t4_flip_step", 32'(f_col), 2);
      tick;
      tick;
      tick;
      chk("t4_flip_delay", 32'(f_col), 2);
      tick;
      chk("t4_flip_rep", 32'(f_col), 3);
      set_btn(1, 5'b0);
      tick;
      tick;

      // 5: shots
      tap(1, B_UP);
      for (int k = 0; k < 4; k++) tap(1, B_RT);
      chk("t5_cell37", 32'(f_cell), 37);
      set_btn(1, B_SL);
      for (int k = 0; k < 5; k++) begin
         tick;
         chk($sformatf("t5_shot_c%0d", k), 32'(f_shot), (k == 0) ? 1 : 0);
         chk($sformatf("t5_scell_c%0d", k), 32'(f_scell), 37);
      end
      set_btn(1, 5'b0);
      tick;
      chk("t5_shot_rel", 32'(f_shot), 0);
      en[1] = 1'b0;
      set_btn(1, B_SL);
      tick;
      chk("t5_dis_shot", 32'(f_shot), 0);
      en[1] = 1'b1;
      tick;
      chk("t5_en_held_shot", 32'(f_shot), 0);
      tick;
      chk("t5_en_held_shot2", 32'(f_shot), 0);
      set_btn(1, 5'b0);
      tick;
      set_btn(1, B_RT | B_SL);
      tick;
      set_btn(1, 5'b0);
      chk("t5_mv_shot",  32'(f_shot),  1);
      chk("t5_mv_scell", 32'(f_scell), 37);
      chk("t5_mv_col",   32'(f_col),   8);
      tick;
      chk("t5_mv_shot_off", 32'(f_shot), 0);
      en[1] = 1'b0;
      set_btn(1, B_RT);
      tick;
      chk("t5_dis_col", 32'(f_col), 8);
      en[1] = 1'b1;
      tick;
      tick;
      chk("t5_en_held_col", 32'(f_col), 8);
      set_btn(1, 5'b0);
      tick;
      tap(1, B_RT);
      chk("t5_repress_col", 32'(f_col), 9);

      // 6: 8x12 board, corner, reset during repeat
      set_btn(3, B_DN | B_RT);
      for (int k = 0; k < 26; k++) tick;
      chk("t6_row",  32'(s_row),  7);
      chk("t6_col",  32'(s_col),  11);
      chk("t6_cell", 32'(s_cell), 95);
      set_btn(3, 5'b0);
      tick;
      set_btn(3, B_LF);
      for (int k = 0; k < 7; k++) tick;
      chk("t6_left_col", 32'(s_col), 8);
      set_btn(3, 5'b0);
      tick;
      set_btn(3, B_RT);
      for (int k = 0; k < 6; k++) tick;
      chk("t6_rep_col", 32'(s_col), 10);
      rst[3] = 1'b1;
      tick;
      chk("t6_rst_row",  32'(s_row),  0);
      chk("t6_rst_col",  32'(s_col),  0);
      chk("t6_rst_cell", 32'(s_cell), 0);
      rst[3] = 1'b0;
      tick;
      chk("t6_newpress_col", 32'(s_col), 1);
      tick;
      tick;
      tick;
      chk("t6_delay_col", 32'(s_col), 1);
      tick;
      chk("t6_delay_step", 32'(s_col), 2);
      set_btn(3, 5'b0);
      tick;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/grid_cursor_ctrl.md
Name: grid_cursor_ctrl

Overview:
Parametrised successor to the fixed 10x10 board cursor. Tracks a row/col cursor on a ROWS x COLS grid and drives the flat cell index to the board/VGA logic. Adds optional wrap-around, hold-to-auto-repeat per axis and an enable gate for turn control. Emits a one-cycle shot_select pulse together with the captured cell index.

Parameters:
ROWS, 10, grid rows (2..64)
COLS, 10, grid columns (2..64)
WRAP, 0, 0 = saturate at edges, 1 = wrap to opposite edge
REPEAT_DELAY, 50_000_000, cycles a direction must be held before the first auto-repeat step (>=2)
REPEAT_RATE, 10_000_000, cycles between subsequent auto-repeat steps (>=1)
Derived localparams: RW = clog2(ROWS), CWD = clog2(COLS), CELL_W = clog2(ROWS*COLS).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = player's turn; 0 freezes the cursor and blocks shots
btn_up  in  1  decrement row (debounced, synchronous to clk)
btn_down  in  1  increment row
btn_left  in  1  decrement column
btn_right  in  1  increment column
btn_select  in  1  fire request
cursor_row  out  RW  current row
cursor_col  out  CWD  current column
selected_cell  out  CELL_W  row*COLS+col, combinational from the row/col registers
shot_select  out  1  one-cycle pulse per accepted fire
shot_cell  out  CELL_W  selected_cell captured when shot_select was set; held until next shot

Behaviour:
- Reset (synchronous): row=0, col=0, shot_select=0, shot_cell=0, both axis FSMs IDLE, all prev-button registers 0. A button held through reset deassertion therefore counts as a new press.
- Per axis, dir = NONE if both or neither button is high, else DEC/INC. Axes are independent, so diagonal moves are legal.
- Axis FSM: IDLE, DELAY, REPEAT, with counter cnt.
  - IDLE: dir!=NONE -> step once, cnt=0, go to DELAY.
  - DELAY: dir unchanged -> cnt++; at cnt==REPEAT_DELAY-1, step, cnt=0, go to REPEAT.
  - REPEAT: dir unchanged -> cnt++; at cnt==REPEAT_RATE-1, step, cnt=0.
  - Any state: dir==NONE -> IDLE. Direction flips (INC<->DEC) without passing through NONE: step immediately in the new direction, cnt=0, go to DELAY.
- Latency: a step is visible on the register one clock after the cycle the press is sampled. For a hold starting at cycle 0, steps land at edges 1, 1+REPEAT_DELAY, 1+REPEAT_DELAY+REPEAT_RATE, and so on.
- Step arithmetic:
  - WRAP=0: DEC at 0 and INC at max (ROWS-1 / COLS-1) leave the value unchanged. The FSM still advances.
  - WRAP=1: DEC at 0 goes to max; INC at max goes to 0.
- enable=0: no steps and no shots. Axis FSMs are forced to IDLE, but the prev-dir registers keep sampling. A button still held when enable rises does not move the cursor until it is released and pressed again.
- shot_select = btn_select & ~select_prev & enable, registered. It is a one-cycle pulse one clock after the rising edge. shot_cell loads selected_cell in the same clock edge.
- select_prev updates every cycle regardless of enable. A press while disabled and held into enable=1 never fires.
- Same-cycle move and select: shot_cell takes the pre-move index, i.e. the value the cursor held when select was sampled.
- selected_cell never exceeds ROWS*COLS-1; multiply in CELL_W bits.

Decomposition:
- battleship_pkg holds: GRID_ROWS/GRID_COLS defaults, the dir_t enum (DIR_NONE, DIR_DEC, DIR_INC) and the rep_state_t enum (IDLE, DELAY, REPEAT).
- Sub-module axis_stepper(MAX, WRAP, REPEAT_DELAY, REPEAT_RATE, width W) owns one axis FSM, its counter and the position register. It is instantiated twice: rows and columns.
- Select edge detection and shot capture live in the top module.

Test Plan:
1. Defaults; reset; btn_down high for 1 cycle -> row=1, col=0, selected_cell=10 on the following cycle; shot_select stays 0.
2. REPEAT_DELAY=4, REPEAT_RATE=2; hold btn_right 10 cycles from (0,0) -> col steps at edges 1,5,7,9; final col=4; release -> no further steps.
3. WRAP=0: btn_up at row 0 -> row stays 0. WRAP=1: btn_up from (0,0) -> row=9, cell=90; btn_left -> col=9, cell=99.
4. btn_up+btn_down held together -> row unchanged; btn_left+btn_down from (3,3) -> (4,2), cell=42; flip left->right mid-hold -> immediate col+1 and DELAY restarts.
5. Cursor at (3,7): hold btn_select 5 cycles -> exactly one shot_select pulse, shot_cell=37. With enable=0, press select -> no pulse; raise enable while still held -> no pulse.
6. ROWS=8, COLS=12: drive to (7,11) -> cell=95. Assert reset mid-REPEAT with btn_right held -> next cycle (0,0); after reset release, col=1 (new press), then DELAY timing restarts.
